// File: rtl/axil_chk_pkg.sv
`default_nettype none
// axil_chk_pkg -- shared FSM state type, response code and pattern function for the AXI4-Lite RW checker.
// rev 1.0
package axil_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int         IDX_W     = 8;
  localparam int         ERR_W     = 9;

  // Full 64-bit result; callers truncate to their data width, which gives the wrap.
  function automatic logic [63:0] pattern_word(input logic [63:0]      seed,
                                               input logic [IDX_W-1:0] index,
                                               input logic             invert);
    logic [63:0] v;
    v = seed + {56'd0, index};
    return invert ? ~v : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_chk_pattern_gen.sv
`default_nettype none
// axil_chk_pattern_gen -- combinational word address and test pattern for a register index.
// rev 1.0
module axil_chk_pattern_gen
  import axil_chk_pkg::*;
#(
  parameter int          C_ADDR_WIDTH   = 32,
  parameter int          C_DATA_WIDTH   = 32,
  parameter logic [63:0] C_BASE_ADDR    = 64'd0,
  parameter logic [63:0] C_START_VALUE  = 64'd1,
  parameter int          C_PATTERN_MODE = 0
) (
  input  logic [IDX_W-1:0]        index,
  output logic [C_ADDR_WIDTH-1:0] addr,
  output logic [C_DATA_WIDTH-1:0] data
);

  localparam logic [63:0] STRIDE = 64'(C_DATA_WIDTH / 8);

  assign addr = C_ADDR_WIDTH'(C_BASE_ADDR + {56'd0, index} * STRIDE);
  assign data = C_DATA_WIDTH'(pattern_word(C_START_VALUE, index, C_PATTERN_MODE != 0));

endmodule
`default_nettype wire

// File: rtl/axil_seq_rw_checker.sv
`default_nettype none
// axil_seq_rw_checker -- AXI4-Lite master: writes a pattern to N registers, reads back, reports errors.
// rev 1.0
module axil_seq_rw_checker
  import axil_chk_pkg::*;
#(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter int          C_NUM_REGS         = 4,
  parameter logic [63:0] C_BASE_ADDR        = 64'd0,
  parameter logic [63:0] C_START_VALUE      = 64'd1,
  parameter int          C_PATTERN_MODE     = 0,
  parameter int          C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic                            timeout,
  output logic [ERR_W-1:0]                err_count,
  output logic [IDX_W-1:0]                first_err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int               TMO_W    = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(C_TIMEOUT_CYCLES - 1);
  localparam bit               TMO_EN   = (C_TIMEOUT_CYCLES != 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_REGS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t                          state, state_next;
  logic [IDX_W-1:0]                idx;
  logic [TMO_W-1:0]                phase_cnt;
  logic                            aw_done, w_done;
  logic                            tmo_hit, tmo_fire, last, record_err;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   pat_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   pat_data;

  axil_chk_pattern_gen #(
    .C_ADDR_WIDTH   (C_M_AXI_ADDR_WIDTH),
    .C_DATA_WIDTH   (C_M_AXI_DATA_WIDTH),
    .C_BASE_ADDR    (C_BASE_ADDR),
    .C_START_VALUE  (C_START_VALUE),
    .C_PATTERN_MODE (C_PATTERN_MODE)
  ) u_pattern (
    .index (idx),
    .addr  (pat_addr),
    .data  (pat_data)
  );

  assign last         = (idx == LAST_IDX);
  assign tmo_hit      = TMO_EN && (phase_cnt == TMO_LAST);
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = '1;
  assign busy         = (state != ST_IDLE) && (state != ST_DONE);
  assign done         = (state == ST_DONE);
  assign pass         = done && (err_count == '0) && !timeout;

  // A read beat with both a bad response and bad data is still a single error.
  assign record_err =
      ((state == ST_WR_RESP) && m_axi_bvalid && (m_axi_bresp != RESP_OKAY)) ||
      ((state == ST_RD_DATA) && m_axi_rvalid &&
       ((m_axi_rresp != RESP_OKAY) || (m_axi_rdata != pat_data)));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next    = state;
    tmo_fire      = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_wdata   = '0;
    m_axi_araddr  = '0;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_WR_REQ;
      ST_WR_REQ: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        m_axi_awaddr  = pat_addr;
        m_axi_wdata   = pat_data;
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_next = ST_WR_RESP;
        else if (tmo_hit) tmo_fire = 1'b1;
      end
      ST_WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = last ? ST_RD_REQ : ST_WR_REQ;
        else if (tmo_hit) tmo_fire = 1'b1;
      end
      ST_RD_REQ: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = pat_addr;
        if (m_axi_arready) state_next = ST_RD_DATA;
        else if (tmo_hit) tmo_fire = 1'b1;
      end
      ST_RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_next = last ? ST_DONE : ST_RD_REQ;
        else if (tmo_hit) tmo_fire = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
    if (tmo_fire) state_next = ST_DONE;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      idx           <= '0;
      phase_cnt     <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      // Every state change (including WR_RESP->WR_REQ per register) restarts the phase timer.
      phase_cnt <= (state_next != state) ? '0 : phase_cnt + TMO_W'(1);
      if (tmo_fire) timeout <= 1'b1;
      if (record_err) begin
        if (err_count == '0)     first_err_idx <= idx;
        if (err_count != ERR_MAX) err_count    <= err_count + ERR_W'(1);
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx           <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
          end
        end
        ST_WR_REQ: begin
          if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
          if (m_axi_wvalid && m_axi_wready)   w_done  <= 1'b1;
        end
        ST_WR_RESP: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (m_axi_bvalid) idx <= last ? '0 : idx + IDX_W'(1);
        end
        ST_RD_DATA: if (m_axi_rvalid && !last) idx <= idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_seq_rw_checker.sv
`default_nettype none
// tb_axil_seq_rw_checker -- checker against a fault-injecting memory slave and an always-ready
// slave with inverted/wrapping pattern parameters; expectations come from a small fault model.
module tb_axil_seq_rw_checker;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: defaults, short timeout ----------------
  logic        a_start = 1'b0;
  logic        a_busy, a_done, a_pass, a_timeout;
  logic [8:0]  a_err;
  logic [7:0]  a_first;
  logic [31:0] a_awaddr, a_wdata, a_araddr, a_rdata;
  logic [2:0]  a_awprot, a_arprot;
  logic [3:0]  a_wstrb;
  logic        a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
  logic        a_arvalid, a_arready, a_rvalid, a_rready;
  logic [1:0]  a_bresp, a_rresp;

  axil_seq_rw_checker #(.C_TIMEOUT_CYCLES(TMO)) dut_a (
    .ACLK(aclk), .ARESETN(aresetn), .start(a_start), .busy(a_busy), .done(a_done),
    .pass(a_pass), .timeout(a_timeout), .err_count(a_err), .first_err_idx(a_first),
    .m_axi_awaddr(a_awaddr), .m_axi_awprot(a_awprot), .m_axi_awvalid(a_awvalid),
    .m_axi_awready(a_awready), .m_axi_wdata(a_wdata), .m_axi_wstrb(a_wstrb),
    .m_axi_wvalid(a_wvalid), .m_axi_wready(a_wready), .m_axi_bresp(a_bresp),
    .m_axi_bvalid(a_bvalid), .m_axi_bready(a_bready), .m_axi_araddr(a_araddr),
    .m_axi_arprot(a_arprot), .m_axi_arvalid(a_arvalid), .m_axi_arready(a_arready),
    .m_axi_rdata(a_rdata), .m_axi_rresp(a_rresp), .m_axi_rvalid(a_rvalid),
    .m_axi_rready(a_rready)
  );

  // ---------------- DUT B: inverted pattern, seed wraps ----------------
  logic        b_start = 1'b0;
  logic        b_busy, b_done, b_pass, b_timeout;
  logic [8:0]  b_err;
  logic [7:0]  b_first;
  logic [31:0] b_awaddr, b_wdata, b_araddr, b_rdata;
  logic [2:0]  b_awprot, b_arprot;
  logic [3:0]  b_wstrb;
  logic        b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
  logic        b_arvalid, b_arready, b_rvalid, b_rready;
  logic [1:0]  b_bresp, b_rresp;

  axil_seq_rw_checker #(.C_PATTERN_MODE(1), .C_START_VALUE(64'hFFFF_FFFF)) dut_b (
    .ACLK(aclk), .ARESETN(aresetn), .start(b_start), .busy(b_busy), .done(b_done),
    .pass(b_pass), .timeout(b_timeout), .err_count(b_err), .first_err_idx(b_first),
    .m_axi_awaddr(b_awaddr), .m_axi_awprot(b_awprot), .m_axi_awvalid(b_awvalid),
    .m_axi_awready(b_awready), .m_axi_wdata(b_wdata), .m_axi_wstrb(b_wstrb),
    .m_axi_wvalid(b_wvalid), .m_axi_wready(b_wready), .m_axi_bresp(b_bresp),
    .m_axi_bvalid(b_bvalid), .m_axi_bready(b_bready), .m_axi_araddr(b_araddr),
    .m_axi_arprot(b_arprot), .m_axi_arvalid(b_arvalid), .m_axi_arready(b_arready),
    .m_axi_rdata(b_rdata), .m_axi_rresp(b_rresp), .m_axi_rvalid(b_rvalid),
    .m_axi_rready(b_rready)
  );

  // ---------------- Slave A: memory with delays and fault injection ----------------
  logic [31:0] mem_a [256];
  int          fix_aw = 0, fix_w = 0, fix_ar = 0, fix_b = 0, fix_r = 0;
  int          rnd_aw = 0, rnd_w = 0, rnd_ar = 0, rnd_b = 0, rnd_r = 0;
  int          cur_aw, cur_w, cur_ar, cur_b, cur_r;
  bit          rnd_mode = 1'b0, aw_stuck = 1'b0;
  logic [3:0]  wr_err_mask = '0, rd_err_mask = '0, corrupt_mask = '0;
  logic [31:0] corrupt_val = '0;
  int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
  int          aw_hs_n = 0, w_hs_n = 0;
  logic        have_aw, have_w, ar_pend;
  logic [7:0]  wa_idx, ra_idx;
  logic [31:0] wd;

  always_comb begin
    cur_aw = rnd_mode ? rnd_aw : fix_aw;
    cur_w  = rnd_mode ? rnd_w  : fix_w;
    cur_ar = rnd_mode ? rnd_ar : fix_ar;
    cur_b  = rnd_mode ? rnd_b  : fix_b;
    cur_r  = rnd_mode ? rnd_r  : fix_r;
  end

  assign a_awready = !aw_stuck && (aw_wait >= cur_aw);
  assign a_wready  = (w_wait >= cur_w);
  assign a_arready = (ar_wait >= cur_ar);

  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
      have_aw <= 1'b0; have_w <= 1'b0; ar_pend <= 1'b0;
      a_bvalid <= 1'b0; a_rvalid <= 1'b0; a_bresp <= 2'b00; a_rresp <= 2'b00; a_rdata <= '0;
    end else begin
      if (a_awvalid && a_awready) begin
        aw_wait <= 0; have_aw <= 1'b1; wa_idx <= a_awaddr[9:2]; aw_hs_n <= aw_hs_n + 1;
        rnd_aw <= int'($urandom_range(0, 3));
      end else if (a_awvalid) aw_wait <= aw_wait + 1;
      if (a_wvalid && a_wready) begin
        w_wait <= 0; have_w <= 1'b1; wd <= a_wdata; w_hs_n <= w_hs_n + 1;
        rnd_w <= int'($urandom_range(0, 3));
      end else if (a_wvalid) w_wait <= w_wait + 1;
      if (a_bvalid) begin
        if (a_bready) a_bvalid <= 1'b0;
      end else if (have_aw && have_w) begin
        if (b_wait >= cur_b) begin
          mem_a[wa_idx] <= wd;
          a_bvalid <= 1'b1;
          a_bresp  <= (wa_idx < 8'd4 && wr_err_mask[wa_idx[1:0]]) ? 2'b10 : 2'b00;
          have_aw <= 1'b0; have_w <= 1'b0; b_wait <= 0;
          rnd_b <= int'($urandom_range(0, 3));
        end else b_wait <= b_wait + 1;
      end
      if (a_arvalid && a_arready) begin
        ar_wait <= 0; ar_pend <= 1'b1; ra_idx <= a_araddr[9:2];
        rnd_ar <= int'($urandom_range(0, 3));
      end else if (a_arvalid) ar_wait <= ar_wait + 1;
      if (a_rvalid) begin
        if (a_rready) a_rvalid <= 1'b0;
      end else if (ar_pend) begin
        if (r_wait >= cur_r) begin
          a_rvalid <= 1'b1;
          a_rdata  <= (ra_idx < 8'd4 && corrupt_mask[ra_idx[1:0]]) ? corrupt_val : mem_a[ra_idx];
          a_rresp  <= (ra_idx < 8'd4 && rd_err_mask[ra_idx[1:0]]) ? 2'b10 : 2'b00;
          ar_pend <= 1'b0; r_wait <= 0;
          rnd_r <= int'($urandom_range(0, 3));
        end else r_wait <= r_wait + 1;
      end
    end
  end

  // ---------------- Slave B: always-ready memory, single-cycle responses ----------------
  logic [31:0] mem_b [256];
  assign b_awready = 1'b1;
  assign b_wready  = 1'b1;
  assign b_arready = 1'b1;
  assign b_bresp   = 2'b00;
  assign b_rresp   = 2'b00;

  always @(posedge aclk) begin
    if (!aresetn) begin
      b_bvalid <= 1'b0; b_rvalid <= 1'b0; b_rdata <= '0;
    end else begin
      if (b_awvalid && b_wvalid) begin
        mem_b[b_awaddr[9:2]] <= b_wdata; b_bvalid <= 1'b1;
      end else if (b_bvalid && b_bready) b_bvalid <= 1'b0;
      if (b_arvalid) begin
        b_rvalid <= 1'b1; b_rdata <= mem_b[b_araddr[9:2]];
      end else if (b_rvalid && b_rready) b_rvalid <= 1'b0;
    end
  end

  // ---------------- Reference model ----------------
  function automatic logic [31:0] model_pat_a(input int i);
    return 32'(64'd1 + 64'(i));
  endfunction

  function automatic logic [31:0] model_pat_b(input int i);
    logic [63:0] s;
    s = 64'hFFFF_FFFF + 64'(i);
    return ~s[31:0];
  endfunction

  function automatic int model_err(input logic [3:0] wr, input logic [3:0] rd, input logic [3:0] co);
    return $countones(wr) + $countones(rd | co);
  endfunction

  // All writes precede all reads, so the earliest write fault wins over any read fault.
  function automatic int model_first(input logic [3:0] wr, input logic [3:0] rd, input logic [3:0] co);
    logic [3:0] r;
    r = rd | co;
    for (int i = 0; i < N; i++) if (wr[i]) return i;
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_done"}, a_done, 0);
    check({tag, "_pass"}, a_pass, 0);
    check({tag, "_timeout"}, a_timeout, 0);
    check({tag, "_err"}, a_err, 0);
    check({tag, "_first"}, a_first, 0);
    check({tag, "_valids"}, {a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready}, 0);
    check({tag, "_addr_data"}, {a_awaddr, a_araddr}, 0);
    check({tag, "_wdata"}, a_wdata, 0);
  endtask

  task automatic run_a(input string tag, input logic [3:0] wr, input logic [3:0] rd,
                       input logic [3:0] co, input logic [31:0] cval);
    int aw0, w0, cyc, e;
    wr_err_mask = wr; rd_err_mask = rd; corrupt_mask = co; corrupt_val = cval;
    aw0 = aw_hs_n; w0 = w_hs_n;
    @(negedge aclk) a_start = 1'b1;
    @(negedge aclk) a_start = 1'b0;
    cyc = 0;
    while (a_done !== 1'b1 && cyc < 2000) begin
      @(negedge aclk);
      cyc++;
    end
    e = model_err(wr, rd, co);
    check({tag, "_done"}, a_done, 1);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_pass"}, a_pass, 64'(e == 0));
    check({tag, "_err_count"}, a_err, 64'(e));
    check({tag, "_first_err_idx"}, a_first, 64'(model_first(wr, rd, co)));
    check({tag, "_timeout"}, a_timeout, 0);
    check({tag, "_aw_handshakes"}, 64'(aw_hs_n - aw0), N);
    check({tag, "_w_handshakes"}, 64'(w_hs_n - w0), N);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_mem%0d", tag, i), mem_a[i], model_pat_a(i));
  endtask

  initial begin
    int n, cyc;
    logic [3:0] wr, rd, co;

    repeat (3) @(negedge aclk);
    check_reset_a("reset");
    check("reset_wstrb", a_wstrb, 4'hF);
    check("reset_prot", {a_awprot, a_arprot}, 0);
    aresetn = 1'b1;
    @(negedge aclk);

    run_a("default", 4'b0000, 4'b0000, 4'b0000, 32'h0);
    run_a("corrupt2", 4'b0000, 4'b0000, 4'b0100, 32'h0000_DEAD);
    fix_aw = 3;
    run_a("aw_late", 4'b0000, 4'b0000, 4'b0000, 32'h0);
    fix_aw = 0; fix_w = 3;
    run_a("w_late", 4'b0000, 4'b0000, 4'b0000, 32'h0);
    fix_w = 0;
    run_a("slverr", 4'b0010, 4'b1000, 4'b0000, 32'h0);

    // Write address channel never accepts: the phase timer must end the test.
    aw_stuck = 1'b1;
    @(negedge aclk) a_start = 1'b1;
    @(negedge aclk) a_start = 1'b0;
    n = 0; cyc = 0;
    while (a_done !== 1'b1 && cyc < 200) begin
      if (a_awvalid) n++;
      @(negedge aclk);
      cyc++;
    end
    check("tmo_awvalid_cycles", 64'(n), TMO);
    check("tmo_timeout", a_timeout, 1);
    check("tmo_done", a_done, 1);
    check("tmo_pass", a_pass, 0);
    check("tmo_busy", a_busy, 0);
    check("tmo_valids", {a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready}, 0);
    aw_stuck = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk) aresetn = 1'b1;
    @(negedge aclk);

    // Asynchronous reset while waiting for read data of register 1.
    fix_r = 3;
    wr_err_mask = '0; rd_err_mask = '0; corrupt_mask = '0;
    @(negedge aclk) a_start = 1'b1;
    @(negedge aclk) a_start = 1'b0;
    cyc = 0;
    while (!(a_arvalid && a_arready && a_araddr == 32'h4) && cyc < 500) begin
      @(negedge aclk);
      cyc++;
    end
    check("midrst_reached_ar1", {a_arvalid, a_arready}, 2'b11);
    @(negedge aclk);
    check("midrst_in_rd_data", a_rready, 1);
    #1 aresetn = 1'b0;
    #1 check_reset_a("midrst");
    @(negedge aclk) aresetn = 1'b1;
    fix_r = 0;
    run_a("after_reset", 4'b0000, 4'b0000, 4'b0000, 32'h0);

    // Randomized slave latencies and fault placement.
    rnd_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wr = 4'($urandom) & 4'($urandom);
      rd = 4'($urandom) & 4'($urandom);
      co = 4'($urandom) & 4'($urandom);
      run_a($sformatf("rand%0d", k), wr, rd, co, $urandom | 32'h8000_0000);
    end
    rnd_mode = 1'b0;

    // Inverted pattern with wrapping seed, always-ready slave: minimum latency 4 cycles/register.
    @(negedge aclk) b_start = 1'b1;
    @(negedge aclk) b_start = 1'b0;
    n = 0; cyc = 0;
    while (b_done !== 1'b1 && cyc < 500) begin
      if (b_busy) n++;
      @(negedge aclk);
      cyc++;
    end
    check("inv_done", b_done, 1);
    check("inv_pass", b_pass, 1);
    check("inv_err", b_err, 0);
    check("inv_busy_cycles", 64'(n), 4 * N);
    for (int i = 0; i < N; i++)
      check($sformatf("inv_mem%0d", i), mem_b[i], model_pat_b(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
